// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR draw controller: width, default seed,
// the advance function and the FSM state encoding.
package lfsr_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 8'h01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Fibonacci step; an all-zero state would lock up, so it escapes to 01.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        if (l == '0) begin
            return {{(LFSR_W-1){1'b0}}, 1'b1};
        end
        return {l[4] ^ l[3] ^ l[2] ^ l[0], l[7:1]};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The winner output is combinational; the
// pointer remembers the last winner so the other requester wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] win
);

    // 1 means requester 1 won last; reset value lets requester 0 win the first tie
    logic last_win;

    // Pick the winner: a lone request wins outright, a tie goes to the non-last winner
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = last_win ? 2'b01 : 2'b10;
        end
    end

    // Record the winner whenever a grant is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= 1'b1;
        end else if (|req) begin
            last_win <= win[1];
        end
    end

endmodule

// File: rtl/lfsr_draw_ctrl.sv
// Owns the 8-bit LFSR: seed loading, divided free-run, single-step and idle
// hold, and shares it between two requesters through a round-robin arbiter.
module lfsr_draw_ctrl
    import lfsr_pkg::*;
#(
    parameter int                DIV      = 4,
    parameter logic [LFSR_W-1:0] SEED_RST = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    input  logic              load,
    input  logic              run,
    input  logic              step,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    output logic [LFSR_W-1:0] rnd,
    output logic [LFSR_W-1:0] lfsr_out,
    output logic              running
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        div_cnt;
    logic [7:0]        div_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [1:0]        eff;
    logic [1:0]        win;
    logic              tick;
    logic              adv;

    // A requester that was just granted sits out one cycle
    assign eff = req & ~gnt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eff),
        .win   (win)
    );

    // Next state, divider and LFSR value; all advance causes merge into one step
    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE) begin
            if (run) state_nxt = ST_RUN;
        end else begin
            if (!run) state_nxt = ST_IDLE;
        end

        tick = (state == ST_RUN) && (div_cnt == DIV_LAST);

        div_nxt = '0;
        if (state_nxt == state && state == ST_RUN && !tick) begin
            div_nxt = div_cnt + 8'd1;
        end

        adv = tick || (state == ST_IDLE && step) || (|win);

        lfsr_nxt = lfsr;
        if (load) begin
            lfsr_nxt = seed;
        end else if (adv) begin
            lfsr_nxt = lfsr_next(lfsr);
        end
    end

    // State, divider, LFSR and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            lfsr    <= SEED_RST;
            gnt     <= '0;
            rnd     <= '0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            lfsr    <= lfsr_nxt;
            gnt     <= win;
            running <= (state_nxt == ST_RUN);
            if (|win) begin
                rnd <= lfsr;
            end
        end
    end

    assign lfsr_out = lfsr;

endmodule

// File: tb/tb_lfsr_draw_ctrl.sv
// Directed bench for lfsr_draw_ctrl: one DIV=4 instance and one DIV=1
// instance share the same stimulus.
module tb_lfsr_draw_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seed;
    logic       load;
    logic       run;
    logic       step;
    logic [1:0] req;

    logic [1:0] gnt4, gnt1;
    logic [7:0] rnd4, rnd1;
    logic [7:0] lfsr4, lfsr1;
    logic       running4, running1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_draw_ctrl #(.DIV(4), .SEED_RST(8'h01)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (seed),
        .load     (load),
        .run      (run),
        .step     (step),
        .req      (req),
        .gnt      (gnt4),
        .rnd      (rnd4),
        .lfsr_out (lfsr4),
        .running  (running4)
    );

    lfsr_draw_ctrl #(.DIV(1), .SEED_RST(8'h01)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (seed),
        .load     (load),
        .run      (run),
        .step     (step),
        .req      (req),
        .gnt      (gnt1),
        .rnd      (rnd1),
        .lfsr_out (lfsr1),
        .running  (running1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seed  = 8'h00;
        load  = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        req   = 2'b00;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (lfsr4 !== 8'h01) begin
            n_fail++; $display("FAIL reset_lfsr got %h want 01", lfsr4);
        end
        n_tests++;
        if (gnt4 !== 2'b00 || rnd4 !== 8'h00) begin
            n_fail++; $display("FAIL reset_gnt_rnd got %b/%h want 00/00", gnt4, rnd4);
        end
        n_tests++;
        if (running4 !== 1'b0) begin
            n_fail++; $display("FAIL reset_running got %b want 0", running4);
        end
    endtask

    task automatic test_run_div4();
        logic [7:0] exp_seq [6] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4};
        logic [7:0] prev;
        do_reset();
        run = 1'b1;
        tick();
        n_tests++;
        if (running4 !== 1'b1 || lfsr4 !== 8'h01) begin
            n_fail++; $display("FAIL run_enter got run=%b lfsr=%h want 1/01", running4, lfsr4);
        end
        prev = 8'h01;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                n_tests++;
                if (lfsr4 !== prev) begin
                    n_fail++; $display("FAIL run_hold[%0d.%0d] got %h want %h", i, j, lfsr4, prev);
                end
            end
            tick();
            n_tests++;
            if (lfsr4 !== exp_seq[i] || running4 !== 1'b1) begin
                n_fail++; $display("FAIL run_adv[%0d] got %h run=%b want %h run=1", i, lfsr4, running4, exp_seq[i]);
            end
            prev = exp_seq[i];
        end
        run = 1'b0;
        tick();
        n_tests++;
        if (running4 !== 1'b0) begin
            n_fail++; $display("FAIL run_exit got %b want 0", running4);
        end
    endtask

    task automatic test_step_in_run();
        do_reset();
        run = 1'b1;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        n_tests++;
        if (lfsr4 !== 8'h01) begin
            n_fail++; $display("FAIL step_in_run got %h want 01", lfsr4);
        end
        tick();
        tick();
        n_tests++;
        if (lfsr4 !== 8'h01) begin
            n_fail++; $display("FAIL step_in_run_hold got %h want 01", lfsr4);
        end
        tick();
        n_tests++;
        if (lfsr4 !== 8'h80) begin
            n_fail++; $display("FAIL step_in_run_tick got %h want 80", lfsr4);
        end
        run = 1'b0;
    endtask

    task automatic test_seed_zero();
        do_reset();
        seed = 8'h00;
        load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++;
        if (lfsr4 !== 8'h00) begin
            n_fail++; $display("FAIL seed0_load got %h want 00", lfsr4);
        end
        tick();
        n_tests++;
        if (lfsr4 !== 8'h00) begin
            n_fail++; $display("FAIL seed0_idle got %h want 00", lfsr4);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        n_tests++;
        if (lfsr4 !== 8'h01) begin
            n_fail++; $display("FAIL seed0_step got %h want 01", lfsr4);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_g [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_r [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        logic [1:0] exp_g1 [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
        logic [7:0] exp_r1 [4] = '{8'hC4, 8'hC4, 8'hE2, 8'hE2};
        logic [1:0] prev;
        do_reset();
        req  = 2'b11;
        prev = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (gnt4 !== exp_g[i] || rnd4 !== exp_r[i]) begin
                n_fail++; $display("FAIL arb_both[%0d] got gnt=%b rnd=%h want gnt=%b rnd=%h", i, gnt4, rnd4, exp_g[i], exp_r[i]);
            end
            n_tests++;
            if ((gnt4 & prev) !== 2'b00) begin
                n_fail++; $display("FAIL arb_consec[%0d] got gnt=%b prev=%b want no overlap", i, gnt4, prev);
            end
            prev = gnt4;
        end
        req = 2'b00;
        tick();
        n_tests++;
        if (gnt4 !== 2'b00 || rnd4 !== 8'h88 || lfsr4 !== 8'hC4) begin
            n_fail++; $display("FAIL arb_idle got gnt=%b rnd=%h lfsr=%h want 00/88/C4", gnt4, rnd4, lfsr4);
        end
        req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (gnt4 !== exp_g1[i] || rnd4 !== exp_r1[i]) begin
                n_fail++; $display("FAIL arb_single[%0d] got gnt=%b rnd=%h want gnt=%b rnd=%h", i, gnt4, rnd4, exp_g1[i], exp_r1[i]);
            end
        end
        req = 2'b00;
        n_tests++;
        if (lfsr4 !== 8'h71) begin
            n_fail++; $display("FAIL arb_single_lfsr got %h want 71", lfsr4);
        end
    endtask

    task automatic test_load_grant();
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        req  = 2'b01;
        load = 1'b1;
        seed = 8'hA5;
        tick();
        req  = 2'b00;
        load = 1'b0;
        n_tests++;
        if (gnt4 !== 2'b01 || rnd4 !== 8'h80 || lfsr4 !== 8'hA5) begin
            n_fail++; $display("FAIL load_grant got gnt=%b rnd=%h lfsr=%h want 01/80/A5", gnt4, rnd4, lfsr4);
        end
        tick();
        n_tests++;
        if (gnt4 !== 2'b00 || rnd4 !== 8'h80 || lfsr4 !== 8'hA5) begin
            n_fail++; $display("FAIL load_grant_after got gnt=%b rnd=%h lfsr=%h want 00/80/A5", gnt4, rnd4, lfsr4);
        end
    endtask

    task automatic test_div1_grant();
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        run  = 1'b1;
        tick();
        n_tests++;
        if (running1 !== 1'b1 || lfsr1 !== 8'h80) begin
            n_fail++; $display("FAIL div1_enter got run=%b lfsr=%h want 1/80", running1, lfsr1);
        end
        req = 2'b01;
        tick();
        req = 2'b00;
        n_tests++;
        if (lfsr1 !== 8'h40 || gnt1 !== 2'b01 || rnd1 !== 8'h80) begin
            n_fail++; $display("FAIL div1_grant got lfsr=%h gnt=%b rnd=%h want 40/01/80", lfsr1, gnt1, rnd1);
        end
        tick();
        n_tests++;
        if (lfsr1 !== 8'h20 || gnt1 !== 2'b00) begin
            n_fail++; $display("FAIL div1_next got lfsr=%h gnt=%b want 20/00", lfsr1, gnt1);
        end
        run = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1;
        req = 2'b11;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (lfsr4 !== 8'h01 || gnt4 !== 2'b00 || rnd4 !== 8'h00 || running4 !== 1'b0) begin
            n_fail++; $display("FAIL async_rst4 got lfsr=%h gnt=%b rnd=%h run=%b want 01/00/00/0", lfsr4, gnt4, rnd4, running4);
        end
        n_tests++;
        if (lfsr1 !== 8'h01 || gnt1 !== 2'b00 || running1 !== 1'b0) begin
            n_fail++; $display("FAIL async_rst1 got lfsr=%h gnt=%b run=%b want 01/00/0", lfsr1, gnt1, running1);
        end
        run = 1'b0;
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (running4 !== 1'b0 || lfsr4 !== 8'h01 || gnt4 !== 2'b00) begin
            n_fail++; $display("FAIL async_release got run=%b lfsr=%h gnt=%b want 0/01/00", running4, lfsr4, gnt4);
        end
    endtask

    initial begin
        test_reset();
        test_run_div4();
        test_step_in_run();
        test_seed_zero();
        test_arbitration();
        test_load_grant();
        test_div1_grant();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lfsr_draw_ctrl.md
Name: lfsr_draw_ctrl

Overview:
- Controller that owns the 8-bit Fibonacci LFSR random source and sequences it: seed loading, free-run at a divided rate, single-step, and idle hold.
- Shares the generator between two requesters through a round-robin arbiter. Each grant delivers one byte and forces a fresh LFSR value.
- Sits between the board controls and the hex display pair. lfsr_out feeds the existing two-digit seven-segment decoder unchanged.

Parameters:
- DIV, 4, clocks per automatic advance in RUN; legal range 1..255.
- SEED_RST, 8'h01, LFSR value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed  in  8  value loaded on load.
- load  in  1  single-cycle pulse; load seed into the LFSR.
- run  in  1  level; 1 = free-run, 0 = idle.
- step  in  1  single-cycle pulse; one advance while idle.
- req  in  2  per-requester draw request, level.
- gnt  out  2  one-hot grant, registered, one cycle wide.
- rnd  out  8  drawn byte, valid in the cycle gnt is non-zero.
- lfsr_out  out  8  current LFSR state, to the display.
- running  out  1  1 while the FSM is in RUN.

Behaviour:
- Reset, asynchronous and immediate:
  - lfsr = SEED_RST, FSM = IDLE, divider = 0.
  - gnt = 0, rnd = 0, running = 0.
  - RR pointer set so that req[0] wins the first tie.
- Advance function:
  - If lfsr == 0, next = 8'h01.
  - Otherwise next = {l[4]^l[3]^l[2]^l[0], l[7:1]}.
  - At most one advance per clock, whatever the number of causes.
- FSM with two states, IDLE and RUN:
  - IDLE -> RUN when run = 1. RUN -> IDLE when run = 0.
  - Divider clears on every transition.
  - In RUN the divider counts 0..DIV-1. The LFSR advances on the edge where divider == DIV-1, and the divider wraps to 0.
  - With DIV = 1 the LFSR advances every cycle.
  - step is honoured only in IDLE and gives one advance on the next edge. step is ignored in RUN.
- Arbitration:
  - Effective requests: eff = req & ~gnt. A requester holding req high is therefore granted at most every other cycle.
  - When eff != 0, the winner is picked round-robin: the requester other than the last winner has priority.
  - On the clock edge: gnt <= one-hot winner, rnd <= current lfsr, LFSR advances, pointer updates.
  - When eff == 0: gnt <= 0 and rnd holds its value.
  - Latency: req sampled at edge N gives gnt and rnd visible after edge N. The requester must drop req in the gnt cycle or it will be granted again two cycles later.
- Priority of LFSR updates: load > (grant or scheduled advance or step).
  - load in the same cycle as a grant: rnd gets the pre-load lfsr, and lfsr takes seed.
  - A grant coinciding with a RUN tick or a step produces one advance only; the divider still wraps.
- seed = 0 may be loaded. lfsr_out then shows 00, and the next advance gives 01.
- running and lfsr_out are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-run or mid-grant: all state is cleared at once, and no grant is pending after release.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_W = 8 and LFSR_SEED_DEFAULT = 8'h01.
  - Function lfsr_next(l), containing the zero-lock escape.
  - FSM state enum {ST_IDLE, ST_RUN}.
- One sub-module, rr_arb2: a 2-way round-robin arbiter with registered pointer, same clk/rst_n, and one-hot output. The LFSR register, FSM and divider stay in the top module.

Test Plan:
- Reset, then run = 1 with DIV = 4: lfsr_out reads 01 → 80 → 40 → 20 → 10 → 88 → C4, with a change every 4th edge and running = 1.
- load seed = 00 in IDLE, then a step pulse: lfsr_out reads 00, then 01. step while in RUN causes no extra advance.
- From reset (lfsr 01, IDLE), req = 2'b11 held:
  - gnt 01 / rnd 01, then gnt 10 / rnd 80, then gnt 01 / rnd 40.
  - gnt is never high in two consecutive cycles for the same requester.
- req[0] and load (seed A5) in the same cycle, lfsr 80: gnt 01, rnd 80, lfsr_out A5.
- RUN with DIV = 1 and a grant on the same edge: exactly one advance (80 → 40).
- Pull rst_n low asynchronously mid-RUN with req active: outputs clear immediately, lfsr_out reads 01 and gnt reads 00. After release, the FSM stays in IDLE if run = 0.
